// File: rtl/bus_mux_reg.sv
// Registered one-hot bus multiplexer for the multicycle datapath.
// Picks one of N_SRC sources with a strobed one-hot select and delivers it
// after LAT clock edges. The output holds between selects. A non-one-hot
// select raises a sticky error flag and bumps a saturating counter.
module bus_mux_reg #(
  parameter int DATA_W   = 16,
  parameter int N_SRC    = 11,
  parameter int LAT      = 1,
  parameter int ZEXT_IDX = 8,
  parameter int ZEXT_W   = 6,
  parameter int ERRCNT_W = 8
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [N_SRC*DATA_W-1:0]   src_flat,
  input  logic [N_SRC-1:0]          sel,
  input  logic                      sel_valid,
  input  logic                      err_clr,
  output logic [DATA_W-1:0]         out,
  output logic                      out_valid,
  output logic [N_SRC-1:0]          out_sel,
  output logic                      err,
  output logic [ERRCNT_W-1:0]       err_cnt
);

  // Keeps only the valid low bits of the narrow (PC) source.
  localparam logic [DATA_W-1:0] ZEXT_MASK = {DATA_W{1'b1}} >> (DATA_W - ZEXT_W);

  logic [DATA_W-1:0] cond_src [N_SRC];
  logic [DATA_W-1:0] mux_data;
  logic              sel_onehot;
  logic              legal;
  logic              illegal;

  // Data, select and valid presented to the output register.
  logic [DATA_W-1:0] stg_data;
  logic [N_SRC-1:0]  stg_sel;
  logic              stg_valid;

  // The narrow source is zero-extended. All other sources pass through.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cond
      if (gi == ZEXT_IDX) begin : g_zext
        assign cond_src[gi] = src_flat[gi*DATA_W +: DATA_W] & ZEXT_MASK;
      end else begin : g_pass
        assign cond_src[gi] = src_flat[gi*DATA_W +: DATA_W];
      end
    end
  endgenerate

  assign sel_onehot = $onehot(sel);
  assign legal      = sel_valid & sel_onehot;
  assign illegal    = sel_valid & ~sel_onehot;

  // AND-OR multiplexer. The result is only consumed when sel is one-hot.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel[i]) mux_data = mux_data | cond_src[i];
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s1_data;
      logic [N_SRC-1:0]  s1_sel;
      logic              s1_valid;

      // First pipeline stage. Its valid bit travels with the data, and the
      // stage never stalls.
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          s1_data  <= '0;
          s1_sel   <= '0;
          s1_valid <= 1'b0;
        end else begin
          s1_valid <= legal;
          if (legal) begin
            s1_data <= mux_data;
            s1_sel  <= sel;
          end
        end
      end

      assign stg_data  = s1_data;
      assign stg_sel   = s1_sel;
      assign stg_valid = s1_valid;
    end else begin : g_lat1
      assign stg_data  = mux_data;
      assign stg_sel   = sel;
      assign stg_valid = legal;
    end
  endgenerate

  // Output register. A new value loads only when a valid slot arrives.
  // Otherwise out and out_sel hold their values.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      out       <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= stg_valid;
      if (stg_valid) begin
        out     <= stg_data;
        out_sel <= stg_sel;
      end
    end
  end

  // Sticky error flag and saturating counter. If a clear and an illegal
  // select arrive on the same edge, the clear wins and that event is dropped.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (err_clr) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (illegal) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg. Two instances share one input stream:
//   a: LAT=1, ERRCNT_W=8
//   b: LAT=2, ERRCNT_W=2
// Expected outputs come from a slot-history model. Each edge records one slot
// (valid/data/select). An instance with latency L shows the slot recorded
// L-1 edges earlier.
module tb_bus_mux_reg;

  localparam int DW = 16;
  localparam int NS = 11;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [NS-1:0] s;
  } slot_t;

  logic              Clock;
  logic              Resetn;
  logic [NS*DW-1:0]  src_flat;
  logic [NS-1:0]     sel;
  logic              sel_valid;
  logic              err_clr;
  logic [DW-1:0]     src [NS];

  logic [DW-1:0]     out_a, out_b;
  logic              ov_a, ov_b;
  logic [NS-1:0]     osel_a, osel_b;
  logic              err_a, err_b;
  logic [7:0]        cnt_a;
  logic [1:0]        cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model state: index 0 is instance a, index 1 is instance b.
  slot_t           hist[$];
  int              lat  [2] = '{1, 2};
  int              cmax [2] = '{255, 3};
  logic [DW-1:0]   m_out [2];
  logic [NS-1:0]   m_sel [2];
  logic            m_ov  [2];
  logic            m_err [2];
  int              m_cnt [2];

  always_comb begin
    src_flat = '0;
    for (int i = 0; i < NS; i++) src_flat[i*DW +: DW] = src[i];
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  bus_mux_reg #(.DATA_W(DW), .N_SRC(NS), .LAT(1), .ZEXT_IDX(8), .ZEXT_W(6), .ERRCNT_W(8)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .src_flat(src_flat), .sel(sel), .sel_valid(sel_valid),
    .err_clr(err_clr), .out(out_a), .out_valid(ov_a), .out_sel(osel_a), .err(err_a), .err_cnt(cnt_a));

  bus_mux_reg #(.DATA_W(DW), .N_SRC(NS), .LAT(2), .ZEXT_IDX(8), .ZEXT_W(6), .ERRCNT_W(2)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .src_flat(src_flat), .sel(sel), .sel_valid(sel_valid),
    .err_clr(err_clr), .out(out_b), .out_valid(ov_b), .out_sel(osel_b), .err(err_b), .err_cnt(cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 2; m++) begin
      m_out[m] = '0; m_sel[m] = '0; m_ov[m] = 1'b0; m_err[m] = 1'b0; m_cnt[m] = 0;
    end
  endtask

  // Value the selected source should deliver, including PC zero-extension.
  function automatic logic [DW-1:0] sel_data();
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NS; k++) begin
      if (sel[k]) d = (k == 8) ? (src[k] & 16'h003F) : src[k];
    end
    return d;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out_a"},  32'(out_a),  32'(m_out[0]));
    chk({tag, ".ov_a"},   32'(ov_a),   32'(m_ov[0]));
    chk({tag, ".sel_a"},  32'(osel_a), 32'(m_sel[0]));
    chk({tag, ".err_a"},  32'(err_a),  32'(m_err[0]));
    chk({tag, ".cnt_a"},  32'(cnt_a),  32'(m_cnt[0]));
    chk({tag, ".out_b"},  32'(out_b),  32'(m_out[1]));
    chk({tag, ".ov_b"},   32'(ov_b),   32'(m_ov[1]));
    chk({tag, ".sel_b"},  32'(osel_b), 32'(m_sel[1]));
    chk({tag, ".err_b"},  32'(err_b),  32'(m_err[1]));
    chk({tag, ".cnt_b"},  32'(cnt_b),  32'(m_cnt[1]));
  endtask

  // One clock edge: record the slot, advance the model, and compare on the
  // falling edge.
  task automatic cycle(input string tag);
    slot_t s;
    int    idx;
    @(posedge Clock);
    s.v = sel_valid && ($countones(sel) == 1);
    s.d = sel_data();
    s.s = sel;
    hist.push_back(s);
    for (int m = 0; m < 2; m++) begin
      idx = hist.size() - lat[m];
      if (idx >= 0 && hist[idx].v) begin
        m_out[m] = hist[idx].d;
        m_sel[m] = hist[idx].s;
        m_ov[m]  = 1'b1;
      end else begin
        m_ov[m] = 1'b0;
      end
      if (err_clr) begin
        m_err[m] = 1'b0;
        m_cnt[m] = 0;
      end else if (sel_valid && !s.v) begin
        m_err[m] = 1'b1;
        if (m_cnt[m] < cmax[m]) m_cnt[m]++;
      end
    end
    @(negedge Clock);
    cyc++;
    $display("cyc %0d %s sel=%h v=%b clr=%b out_a=%h ov_a=%b out_b=%h ov_b=%b cnt_a=%0d cnt_b=%0d",
             cyc, tag, sel, sel_valid, err_clr, out_a, ov_a, out_b, ov_b, cnt_a, cnt_b);
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] seen[$];
    int            r;
    int            b0;
    int            b1;

    Resetn = 1'b0; sel = '0; sel_valid = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < NS; i++) src[i] = 16'hFFFF;
    model_reset();

    // Reset, then idle.
    repeat (2) @(negedge Clock);
    check_all("reset");
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) cycle("idle");

    // Walk every source.
    for (int i = 0; i < NS; i++) src[i] = 16'hA000 + 16'(i);
    for (int i = 0; i < NS; i++) begin
      sel = NS'(1) << i; sel_valid = 1'b1;
      cycle("walk");
      if (i == 8) chk("walk8_zext", 32'(out_a), 32'h0008);
    end
    sel_valid = 1'b0;
    cycle("walk_flush");

    // Hold on illegal select.
    sel = NS'(1) << 3; sel_valid = 1'b1; cycle("sel3");
    sel_valid = 1'b0; cycle("sel3_flush");
    sel = 11'b00000000110; sel_valid = 1'b1; cycle("illegal_multi");
    chk("hold_out", 32'(out_a), 32'hA003);
    chk("ill_cnt1", 32'(cnt_a), 32'd1);
    sel = '0; cycle("illegal_zero");
    chk("ill_cnt2", 32'(cnt_a), 32'd2);

    // Saturation of the 2-bit counter, then clear colliding with an illegal select.
    sel_valid = 1'b0; err_clr = 1'b1; cycle("clr");
    err_clr = 1'b0; sel = 11'b00000011000; sel_valid = 1'b1;
    for (int i = 0; i < 5; i++) cycle("sat");
    chk("sat_cnt_b", 32'(cnt_b), 32'd3);
    chk("sat_cnt_a", 32'(cnt_a), 32'd5);
    err_clr = 1'b1; cycle("clr_wins");
    chk("clr_err_b", 32'(err_b), 32'd0);
    chk("clr_cnt_b", 32'(cnt_b), 32'd0);
    err_clr = 1'b0; sel_valid = 1'b0; cycle("idle2");

    // LAT=2 back-to-back selects of sources 1, 2 and 3.
    src[1] = 16'h1111; src[2] = 16'h2222; src[3] = 16'h3333;
    for (int i = 1; i <= 3; i++) begin
      sel = NS'(1) << i; sel_valid = 1'b1;
      cycle("b2b");
      if (ov_b) seen.push_back(out_b);
    end
    sel_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src[1] = 16'(i); // source changes while idle must not reach out
      cycle("b2b_drain");
      if (ov_b) seen.push_back(out_b);
    end
    chk("b2b_count", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("b2b_0", 32'(seen[0]), 32'h1111);
      chk("b2b_1", 32'(seen[1]), 32'h2222);
      chk("b2b_2", 32'(seen[2]), 32'h3333);
    end

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NS; i++) src[i] = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) begin
        sel = '0;
      end else if (r <= 2) begin
        b0 = $urandom_range(0, NS-1);
        b1 = (b0 + $urandom_range(1, NS-1)) % NS;
        sel = (NS'(1) << b0) | (NS'(1) << b1);
      end else begin
        sel = NS'(1) << $urandom_range(0, NS-1);
      end
      sel_valid = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    err_clr = 1'b0; sel_valid = 1'b0; cycle("rand_flush");

    // Reset asserted while a LAT=2 select is in flight.
    src[5] = 16'h5A5A; sel = NS'(1) << 5; sel_valid = 1'b1;
    @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    #1 Resetn = 1'b1;
    sel_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("post_reset");
      chk("post_reset_ov_b", 32'(ov_b), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
